// File: rtl/seg_scan_disp_if.sv
// Display-side bundle for seg_scan_disp: count in, segment/digit drive and busy out.
// master = count source / observer, slave = the display stage.
interface seg_scan_disp_if;
   logic [5:0] in_cnt;
   logic [6:0] seg_data;
   logic [1:0] seg_com;
   logic       busy;

   modport master (
      output in_cnt,
      input  seg_data,
      input  seg_com,
      input  busy
   );

   modport slave (
      input  in_cnt,
      output seg_data,
      output seg_com,
      output busy
   );
endinterface

// File: rtl/seg_scan_disp.sv
// Seconds count to two multiplexed common-cathode 7-segment digits via subtract-by-ten FSM.
// Optional macro DISP_LZ_BLANK_EN blanks a leading zero in the tens slot.
module seg_scan_disp #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned CNT_MAX  = 59
) (
   input  logic            clk,
   input  logic            rst,
   seg_scan_disp_if.slave  bus
);

   localparam int unsigned SCAN_W = 32;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      LOAD = 2'd2
   } state_t;

   state_t      state;
   logic [5:0]  last_cnt;
   logic [5:0]  work;
   logic [2:0]  tens;
   logic [3:0]  ones;
   logic        err;
   logic [2:0]  disp_tens;
   logic [3:0]  disp_ones;
   logic        disp_err;
   logic [SCAN_W-1:0] scan_cnt;
   logic        digit_sel;
   logic        busy;
   logic [6:0]  seg_data;
   logic [1:0]  seg_com;
   logic [3:0]  digit_c;
   logic [6:0]  seg_c;

   function automatic logic [6:0] seg_enc(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Conversion FSM; display registers change only in LOAD so a reset never leaves a partial value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last_cnt  <= 6'd0;
         work      <= 6'd0;
         tens      <= 3'd0;
         ones      <= 4'd0;
         err       <= 1'b0;
         disp_tens <= 3'd0;
         disp_ones <= 4'd0;
         disp_err  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_cnt != last_cnt) begin
                  last_cnt <= bus.in_cnt;
                  busy     <= 1'b1;
                  if (SCAN_W'(bus.in_cnt) <= SCAN_W'(CNT_MAX)) begin
                     work  <= bus.in_cnt;
                     tens  <= 3'd0;
                     state <= CONV;
                  end else begin
                     err   <= 1'b1;
                     state <= LOAD;
                  end
               end
            end
            CONV: begin
               if (work >= 6'd10) begin
                  work <= work - 6'd10;
                  tens <= tens + 3'd1;
               end else begin
                  ones  <= work[3:0];
                  state <= LOAD;
               end
            end
            LOAD: begin
               disp_tens <= tens;
               disp_ones <= ones;
               disp_err  <= err;
               err       <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Digit slot timer: each slot lasts exactly SCAN_DIV clocks.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt  <= '0;
         digit_sel <= 1'b0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt  <= '0;
         digit_sel <= ~digit_sel;
      end else begin
         scan_cnt  <= scan_cnt + SCAN_W'(1);
      end
   end

   always_comb begin
      digit_c = digit_sel ? {1'b0, disp_tens} : disp_ones;
      seg_c   = seg_enc(digit_c);
      if (disp_err) begin
         seg_c = SEG_DASH;
      end
`ifdef DISP_LZ_BLANK_EN
      else if (digit_sel && (disp_tens == 3'd0)) begin
         seg_c = SEG_BLANK;
      end
`endif
   end

   // Pin register; seg_com is one-hot from the first non-reset edge, so no blanking gap exists.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_com  <= 2'b00;
         seg_data <= SEG_BLANK;
      end else begin
         seg_com  <= digit_sel ? 2'b10 : 2'b01;
         seg_data <= seg_c;
      end
   end

   assign bus.seg_data = seg_data;
   assign bus.seg_com  = seg_com;
   assign bus.busy     = busy;

endmodule

// File: tb/tb_seg_scan_disp.sv
// Scoreboard bench for seg_scan_disp at SCAN_DIV=4: stimulus pushes expected digits,
// a monitor pops on each completed conversion and checks busy length and both slots.
module tb_seg_scan_disp;

   localparam int unsigned SD = 4;
`ifdef DISP_LZ_BLANK_EN
   localparam logic [6:0] TZ = 7'h00;
`else
   localparam logic [6:0] TZ = 7'h3F;
`endif

   typedef struct {
      logic [6:0] tens_seg;
      logic [6:0] ones_seg;
      int         busy_len;
      int         val;
   } exp_t;

   logic clk;
   logic rst;
   exp_t sb_q[$];
   int   n_cmp;
   int   n_bad;
   bit   mon_active;
   bit   rst_prev;

   seg_scan_disp_if bus();

   seg_scan_disp #(.SCAN_DIV(SD), .CNT_MAX(59)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input int d);
      logic [6:0] t [10];
      t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      return t[d];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [6:0] ts, input logic [6:0] os, input int len, input int v);
      exp_t e;
      e.tens_seg = ts;
      e.ones_seg = os;
      e.busy_len = len;
      e.val      = v;
      sb_q.push_back(e);
   endtask

   task automatic push_val(input int v);
      if (v > 59) push_exp(7'h40, 7'h40, 1, v);
      else push_exp((v / 10 == 0) ? TZ : seg_of(v / 10), seg_of(v % 10), v / 10 + 2, v);
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while ((sb_q.size() != 0 || mon_active) && t < 400) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (t >= 400) begin
         n_bad++;
         $display("FAIL conversion_timeout: queue %0d entries left after %0d cycles", sb_q.size(), t);
         sb_q.delete();
      end
   endtask

   task automatic step(input int v);
      @(negedge clk);
      bus.in_cnt = 6'(v);
      wait_done();
   endtask

   // Monitor: a busy fall marks a completed conversion; a re-rise one cycle later is an intermediate result.
   initial begin
      int         run;
      bit         prev;
      exp_t       e;
      logic [6:0] d_one;
      logic [6:0] d_ten;
      run = 0;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            run = 0;
            prev = 1'b0;
         end else if (bus.busy) begin
            run++;
            prev = 1'b1;
         end else if (prev) begin
            prev = 1'b0;
            mon_active = 1'b1;
            @(negedge clk);
            if (rst) begin
               run = 0;
               mon_active = 1'b0;
            end else if (bus.busy) begin
               run = 1;
               prev = 1'b1;
               mon_active = 1'b0;
            end else if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_conversion: busy ran %0d cycles with nothing expected", run);
               run = 0;
               mon_active = 1'b0;
            end else begin
               e = sb_q.pop_front();
               check($sformatf("busy_len_%0d", e.val), 32'(run), 32'(e.busy_len));
               run = 0;
               d_one = 7'bx;
               d_ten = 7'bx;
               for (int i = 0; i < 2 * int'(SD); i++) begin
                  if (i > 0) @(negedge clk);
                  if (bus.seg_com == 2'b01) d_one = bus.seg_data;
                  else if (bus.seg_com == 2'b10) d_ten = bus.seg_data;
               end
               check($sformatf("ones_seg_%0d", e.val), 32'(d_one), 32'(e.ones_seg));
               check($sformatf("tens_seg_%0d", e.val), 32'(d_ten), 32'(e.tens_seg));
               mon_active = 1'b0;
            end
         end
      end
   end

   // Digit enable must be one-hot whenever reset has been released for a full cycle.
   always @(negedge clk) begin
      if (!rst && !rst_prev) begin
         n_cmp++;
         if (bus.seg_com != 2'b01 && bus.seg_com != 2'b10) begin
            n_bad++;
            $display("FAIL seg_com_onehot: got %b required 01 or 10 at %0t", bus.seg_com, $time);
         end
      end
      rst_prev <= rst;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      mon_active = 1'b0;
      rst_prev = 1'b1;
      rst = 1'b1;
      bus.in_cnt = 6'd0;

      repeat (3) @(negedge clk);
      check("reset_seg_com", 32'(bus.seg_com), 32'h0);
      check("reset_seg_data", 32'(bus.seg_data), 32'h0);
      check("reset_busy", 32'(bus.busy), 32'h0);
      rst = 1'b0;

      // Slot dwell and initial digits 0/0.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check($sformatf("dwell_com_%0d", i), 32'(bus.seg_com), ((i / 4) % 2 == 0) ? 32'h1 : 32'h2);
         check($sformatf("dwell_data_%0d", i), 32'(bus.seg_data), ((i / 4) % 2 == 0) ? 32'h3F : 32'(TZ));
      end

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("steady_busy", 32'(bus.busy), 32'h0);
      end

      push_exp(7'h6D, 7'h6F, 7, 59);  step(59);
      push_exp(TZ,    7'h6F, 2, 9);   step(9);
      push_exp(7'h06, 7'h3F, 3, 10);  step(10);
      push_exp(7'h6D, 7'h3F, 7, 50);  step(50);
      push_exp(7'h40, 7'h40, 1, 62);  step(62);
      push_exp(TZ,    7'h07, 2, 7);   step(7);

      // Change to 12 one cycle into the 59 conversion; only 12 must end up displayed.
      push_exp(7'h06, 7'h5B, 3, 12);
      @(negedge clk);
      bus.in_cnt = 6'd59;
      @(negedge clk);
      bus.in_cnt = 6'd12;
      wait_done();

      // Reset during the 45 conversion, then it restarts from last_cnt=0.
      push_exp(7'h66, 7'h6D, 6, 45);
      @(negedge clk);
      bus.in_cnt = 6'd45;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("midreset_busy", 32'(bus.busy), 32'h0);
      check("midreset_seg_com", 32'(bus.seg_com), 32'h0);
      check("midreset_seg_data", 32'(bus.seg_data), 32'h0);
      rst = 1'b0;
      @(negedge clk);
      check("postreset_seg_com", 32'(bus.seg_com), 32'h1);
      check("postreset_ones_zero", 32'(bus.seg_data), 32'h3F);
      wait_done();

      // Seconds sweep 0..59 then wrap to 0.
      for (int v = 0; v < 60; v++) begin
         push_val(v);
         step(v);
      end
      push_val(0);
      step(0);

      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
